// File: rtl/snes_pad_emulator.sv
// SNES/NES controller impersonator: serialises a 16-bit button snapshot on the host latch/clock link.
// Optional SNES_PAD_TIMEOUT_EN aborts a frame when the host clock stalls for TIMEOUT_CYCLES.
module snes_pad_emulator #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       controller_latch,
  input  logic       controller_clk,
  output logic       controller_dout,
  input  logic       button_B,
  input  logic       button_Y,
  input  logic       button_SELECT,
  input  logic       button_START,
  input  logic       button_N,
  input  logic       button_S,
  input  logic       button_W,
  input  logic       button_E,
  input  logic       button_A,
  input  logic       button_X,
  input  logic       button_L,
  input  logic       button_R,
  output logic       busy,
  output logic       frame_done,
  output logic [4:0] bit_index
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("snes_pad_emulator: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_clk_prev;
  logic                   w_latch_s;
  logic                   w_clk_s;
  logic                   w_clk_rise;
  logic [15:0]            w_buttons;
  logic [15:0]            r_shreg;
  logic [15:0]            w_shreg_nxt;
  logic [4:0]             r_bit_idx;
  logic [4:0]             w_bit_nxt;
  logic                   r_frame_done;
  logic                   w_fd_nxt;

  // Host clock idles high, so its chain resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '1;
      r_clk_prev   <= 1'b1;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], controller_latch};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], controller_clk};
      r_clk_prev   <= w_clk_s;
    end
  end

  assign w_latch_s  = r_latch_sync[SYNC_STAGES-1];
  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_prev;

  // Pressed = 1 inside the shift register; the top nibble always reads "not pressed".
  assign w_buttons = {4'b0000, button_R, button_L, button_X, button_A,
                      button_E, button_W, button_S, button_N,
                      button_START, button_SELECT, button_Y, button_B};

`ifdef SNES_PAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) r_to_cnt <= '0;
    else        r_to_cnt <= w_to_nxt;
  end
`endif

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_bit_nxt       = r_bit_idx;
    w_fd_nxt        = 1'b0;
    controller_dout = 1'b1;
    busy            = 1'b0;
`ifdef SNES_PAD_TIMEOUT_EN
    w_to_nxt        = '0;
`endif
    case (r_state)
      IDLE: begin
        if (w_latch_s) begin
          w_state_nxt = LOAD;
          w_shreg_nxt = w_buttons;
          w_bit_nxt   = '0;
        end
      end
      LOAD: begin
        controller_dout = ~r_shreg[0];
        busy            = 1'b1;
        w_bit_nxt       = '0;
        // Keep tracking the buttons until the latch drops; the last sample is the frame.
        if (w_latch_s) w_shreg_nxt = w_buttons;
        else           w_state_nxt = SHIFT;
      end
      SHIFT: begin
        controller_dout = ~r_shreg[0];
        busy            = 1'b1;
        // Latch has priority over a coincident clock edge: abort and reload.
        if (w_latch_s) begin
          w_state_nxt = LOAD;
          w_shreg_nxt = w_buttons;
          w_bit_nxt   = '0;
        end else if (w_clk_rise) begin
          w_shreg_nxt = {1'b1, r_shreg[15:1]};
          w_bit_nxt   = r_bit_idx + 5'd1;
          if (r_bit_idx == 5'd15) begin
            w_state_nxt = DONE;
            w_fd_nxt    = 1'b1;
          end
        end else begin
`ifdef SNES_PAD_TIMEOUT_EN
          if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_to_nxt = r_to_cnt + 1'b1;
          end
`endif
        end
      end
      DONE: begin
        controller_dout = 1'b0;
        if (w_latch_s) begin
          w_state_nxt = LOAD;
          w_shreg_nxt = w_buttons;
          w_bit_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign frame_done = r_frame_done;
  assign bit_index  = r_bit_idx;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed-plus-random bench for snes_pad_emulator acting as host; expected serial words come from the button rules.
module tb_snes_pad_emulator;
  localparam int SYNC    = 2;
  localparam int TO      = 100;
  localparam int LATCH_W = 20;

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        latch  = 1'b0;
  logic        pclk   = 1'b1;
  logic [11:0] btn    = '0;
  logic        dout;
  logic        busy;
  logic        fd;
  logic [4:0]  bidx;

  int n_vec  = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) if (fd) fd_cnt++;

  snes_pad_emulator #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .controller_latch(latch), .controller_clk(pclk), .controller_dout(dout),
    .button_B(btn[0]), .button_Y(btn[1]), .button_SELECT(btn[2]), .button_START(btn[3]),
    .button_N(btn[4]), .button_S(btn[5]), .button_W(btn[6]), .button_E(btn[7]),
    .button_A(btn[8]), .button_X(btn[9]), .button_L(btn[10]), .button_R(btn[11]),
    .busy(busy), .frame_done(fd), .bit_index(bidx)
  );

  // Line level for each serial bit: pressed reads 0, the four padding bits read 1.
  function automatic logic [15:0] pad_word(input logic [11:0] b);
    return {4'hF, ~b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic start_frame(input logic [11:0] b);
    btn   = b;
    latch = 1'b1;
    wait_cyc(LATCH_W);
    chk("load_bidx", 16'(bidx), 16'd0);
    chk("load_busy", 16'(busy), 16'd1);
    chk("load_dout", 16'(dout), 16'(!b[0]));
    latch = 1'b0;
    wait_cyc(SYNC + 3);
  endtask

  // One host clock period per bit: fall, sample dout at the end of the low phase, rise.
  task automatic shift_n(input int from, input int to, input logic [15:0] exp, input int half);
    for (int k = from; k < to; k++) begin
      pclk = 1'b0;
      wait_cyc(half);
      chk($sformatf("bit%0d", k), 16'(dout), 16'(exp[k]));
      chk($sformatf("bidx%0d", k), 16'(bidx), 16'(k));
      pclk = 1'b1;
      wait_cyc(half);
    end
  endtask

  task automatic end_frame(input int fd_before);
    chk("done_pulses", 16'(fd_cnt - fd_before), 16'd1);
    chk("done_dout", 16'(dout), 16'd0);
    chk("done_busy", 16'(busy), 16'd0);
    chk("done_bidx", 16'(bidx), 16'd16);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] b;
    logic [11:0] b2;
    int          f0;
    int          half;

    // Reset state
    wait_cyc(3);
    chk("rst_dout", 16'(dout), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_fd", 16'(fd), 16'd0);
    chk("rst_bidx", 16'(bidx), 16'd0);
    rst_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 2; i++) begin
      pclk = 1'b0; wait_cyc(8); pclk = 1'b1; wait_cyc(8);
    end
    chk("idle_dout", 16'(dout), 16'd1);
    chk("idle_bidx", 16'(bidx), 16'd0);

    // Full frame with B, START, A, R pressed
    f0 = fd_cnt;
    start_frame(12'h909);
    shift_n(0, 16, 16'hF6F6, 10);
    end_frame(f0);
    chk("done_fd_low", 16'(fd), 16'd0);

    // Snapshot hold: buttons change after the latch falls
    b  = 12'($urandom);
    f0 = fd_cnt;
    start_frame(b);
    btn = 12'hFFF;
    shift_n(0, 16, pad_word(b), 8);
    end_frame(f0);
    f0 = fd_cnt;
    start_frame(12'hFFF);
    shift_n(0, 16, 16'hF000, 8);
    end_frame(f0);

    // Mid-frame relatch after 5 edges
    b  = 12'($urandom);
    b2 = 12'($urandom);
    f0 = fd_cnt;
    start_frame(b);
    shift_n(0, 5, pad_word(b), 7);
    start_frame(b2);
    chk("relatch_nofd", 16'(fd_cnt - f0), 16'd0);
    shift_n(0, 16, pad_word(b2), 7);
    end_frame(f0);

    // Latch rise and clock rise in the same cycle
    b  = 12'($urandom);
    b2 = 12'($urandom) | 12'h001;
    f0 = fd_cnt;
    start_frame(b);
    shift_n(0, 4, pad_word(b), 6);
    pclk = 1'b0;
    wait_cyc(6);
    btn   = b2;
    latch = 1'b1;
    pclk  = 1'b1;
    wait_cyc(LATCH_W);
    chk("sim_bidx", 16'(bidx), 16'd0);
    chk("sim_busy", 16'(busy), 16'd1);
    chk("sim_dout", 16'(dout), 16'(!b2[0]));
    latch = 1'b0;
    wait_cyc(SYNC + 3);
    chk("sim_noshift", 16'(bidx), 16'd0);
    chk("sim_dout2", 16'(dout), 16'(!b2[0]));
    shift_n(0, 16, pad_word(b2), 6);
    end_frame(f0);

    // Random frames at random host clock rates
    for (int r = 0; r < 5; r++) begin
      b    = 12'($urandom);
      half = int'($urandom_range(5, 12));
      f0   = fd_cnt;
      start_frame(b);
      shift_n(0, 16, pad_word(b), half);
      end_frame(f0);
    end

    // Host clock stalls after 3 edges
    b  = 12'($urandom);
    f0 = fd_cnt;
    start_frame(b);
    shift_n(0, 3, pad_word(b), 6);
    wait_cyc(40);
    chk("stall_busy_early", 16'(busy), 16'd1);
    wait_cyc(100);
`ifdef SNES_PAD_TIMEOUT_EN
    chk("to_busy", 16'(busy), 16'd0);
    chk("to_dout", 16'(dout), 16'd1);
    chk("to_bidx", 16'(bidx), 16'd0);
    chk("to_nofd", 16'(fd_cnt - f0), 16'd0);
    pclk = 1'b0; wait_cyc(8); pclk = 1'b1; wait_cyc(8);
    chk("to_idle_dout", 16'(dout), 16'd1);
    chk("to_idle_bidx", 16'(bidx), 16'd0);
`else
    chk("stall_busy", 16'(busy), 16'd1);
    chk("stall_bidx", 16'(bidx), 16'd3);
    chk("stall_dout", 16'(dout), 16'(pad_word(b)[3]));
    chk("stall_nofd", 16'(fd_cnt - f0), 16'd0);
`endif

    // Asynchronous reset in the middle of a frame
    b = 12'($urandom);
    start_frame(b);
    shift_n(0, 7, pad_word(b), 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("amid_rst_dout", 16'(dout), 16'd1);
    chk("amid_rst_busy", 16'(busy), 16'd0);
    chk("amid_rst_bidx", 16'(bidx), 16'd0);
    chk("amid_rst_fd", 16'(fd), 16'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 2; i++) begin
      pclk = 1'b0; wait_cyc(8); pclk = 1'b1; wait_cyc(8);
    end
    chk("post_rst_dout", 16'(dout), 16'd1);
    chk("post_rst_busy", 16'(busy), 16'd0);
    chk("post_rst_bidx", 16'(bidx), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/snes_pad_emulator.md
Name: snes_pad_emulator

Overview:
- Device-side end of the SNES/NES controller serial link; the FPGA impersonates a controller.
- Host drives controller_latch and controller_clk; the block serialises a 16-bit button snapshot onto controller_dout.
- Used to drive a real console, or to loop back against the host-side controller reader in bench and board tests.
- Button inputs come from on-board switches or internal game logic.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on controller_latch and controller_clk (legal values 2..4)
TIMEOUT_CYCLES, 50000, clk_50 cycles of host clock inactivity before abort (1 ms at 50 MHz); used only with the optional feature

Ports:
clk_50  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
controller_latch  input  1  host latch, active high, asynchronous to clk_50
controller_clk  input  1  host shift clock, idles high, asynchronous to clk_50
controller_dout  output  1  serial data, active low (0 = pressed)
button_B, button_Y, button_SELECT, button_START, button_N, button_S, button_W, button_E, button_A, button_X, button_L, button_R  input  1 each  active-high pressed flags
busy  output  1  high while a frame is loaded or shifting
frame_done  output  1  one-cycle pulse after the 16th shift
bit_index  output  5  number of shifts completed in the current frame (0..16)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, controller_dout=1, busy=0, frame_done=0, bit_index=0.
  - Shift register and synchroniser flops are all cleared to 0 (latch/clk sync chains to 1 for clk).
- Synchronisation:
  - latch and clk each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised signal.
  - All events below refer to synchronised signals.
- Frame word order, bit0 first: B, Y, SELECT, START, N, S, W, E, A, X, L, R, then bits 12-15 constant "not pressed".
- Output drive: controller_dout = ~shreg[0], so pressed buttons read 0 and the constant bits read 1.
- States:
  - IDLE: controller_dout=1. Clock edges are ignored. Latch high -> LOAD.
  - LOAD:
    - Shift register reloads from the buttons every cycle while latch is high; the last sample before the latch fall is kept.
    - busy=1, bit_index=0; bit0 (B) is presented on dout.
    - Clock edges are ignored while latch is high.
    - Latch falling edge -> SHIFT.
  - SHIFT:
    - Each controller_clk rising edge shifts right by one, fills with 1, and increments bit_index.
    - The new bit appears on dout exactly 1 clk_50 cycle after the synchronised edge, i.e. SYNC_STAGES+1 cycles after the pin edge.
    - When bit_index reaches 16 -> DONE and frame_done pulses that cycle.
  - DONE: controller_dout=0 (matches a real pad after 16 bits), busy=0. Further clock edges are ignored. Latch high -> LOAD.
- Latch rising in SHIFT (mid-frame): abort, go to LOAD, bit_index=0, no frame_done.
- Latch rise and clock rise in the same cycle: latch wins and no shift occurs.
- Button changes during SHIFT do not affect the current frame.
- Reset mid-frame: immediate return to the reset values above.

Optional Feature:
SNES_PAD_TIMEOUT_EN
- Defined:
  - A counter runs in SHIFT; it clears on every clock rising edge and on entry to SHIFT.
  - At TIMEOUT_CYCLES with no edge: go to IDLE, controller_dout=1, busy=0, bit_index=0, no frame_done pulse.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter exists; SHIFT waits indefinitely.

Test Plan:
1. Reset behaviour: assert rst_n=0 mid-SHIFT -> controller_dout=1, busy=0, bit_index=0 asynchronously; after release, clock edges leave dout=1.
2. Full frame: buttons B=1, START=1, A=1, R=1, others 0; latch 12 us, then 16 clock pulses of 6 us high/low.
   - Bits sampled on clock falling edges read 0,1,1,0,1,1,1,1,0,1,1,0,1,1,1,1.
   - frame_done pulses once after the 16th rise; dout=0 afterward.
3. Snapshot hold: change all buttons to 1 after the latch falls -> serialised frame still matches pre-latch values; the next latch picks up all-pressed (bits 0-11 = 0, bits 12-15 = 1).
4. Mid-frame relatch: raise latch after 5 clock edges -> bit_index=0, dout=B again, no frame_done; then 16 edges complete normally.
5. Simultaneous latch and clock rise in the same clk_50 cycle -> no shift, LOAD entered, bit_index=0.
6. With SNES_PAD_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop clocks after 3 edges -> IDLE after 100 cycles, dout=1, busy=0, no frame_done.
   - Without the macro, the same stimulus leaves busy=1 indefinitely.
